// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: drives PC into a combinational instruction memory and queues {pc, instr} for decode.
// Optional misaligned-redirect trap is enabled with `define FETCH_ALIGN_CHECK_EN.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    output logic [31:0] PC_out,
    input  logic [31:0] instruction,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        misalign_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, RUN, TRAP} state_t;

    state_t          state_q;
    logic [31:0]     pc_q;
    logic [CW-1:0]   count_q;
    logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [31:0]     fifo_pc_q    [DEPTH];
    logic [31:0]     fifo_instr_q [DEPTH];

    logic empty, full, pop, push;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign pop   = out_valid & out_ready;
    // A pop frees a slot in the same cycle, so a full queue can still accept.
    assign push  = (state_q == RUN) & fetch_en & ~redirect_valid & (~full | pop);

    assign PC_out    = pc_q;
    assign out_valid = ~empty;
    assign out_pc    = empty ? 32'h0 : fifo_pc_q[rd_ptr_q];
    assign out_instr = empty ? 32'h0 : fifo_instr_q[rd_ptr_q];

`ifdef FETCH_ALIGN_CHECK_EN
    logic misalign_q;
    logic redirect_bad;
    assign redirect_bad = (redirect_pc[1:0] != 2'b00);
    assign misalign_err = misalign_q;
`else
    assign misalign_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc_q[i]    <= '0;
                fifo_instr_q[i] <= '0;
            end
`ifdef FETCH_ALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
        end else if (redirect_valid) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
            pc_q <= redirect_pc;
            if (redirect_bad) begin
                state_q    <= TRAP;
                misalign_q <= 1'b1;
            end else if (state_q == TRAP) begin
                misalign_q <= 1'b0;
                state_q    <= fetch_en ? RUN : IDLE;
            end
`else
            pc_q <= redirect_pc & ~32'h3;
`endif
        end else begin
            if (push) begin
                fifo_pc_q[wr_ptr_q]    <= pc_q;
                fifo_instr_q[wr_ptr_q] <= instruction;
                wr_ptr_q               <= wr_ptr_q + 1'b1;
                pc_q                   <= pc_q + 32'd4;
            end
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(push) - CW'(pop);
            case (state_q)
                IDLE:    if (fetch_en)  state_q <= RUN;
                RUN:     if (!fetch_en) state_q <= IDLE;
                default: state_q <= state_q;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed test-plan steps then random traffic, checked against a queue-based model.
module tb_fetch_sequencer;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_en = 1'b0;
    logic [31:0] PC_out;
    logic [31:0] instruction;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        misalign_err;

    int total = 0;
    int bad = 0;

    // Reference model state
    logic [63:0] mq[$];
    logic [31:0] m_pc;
    bit          m_run;
    bit          m_trap;
    bit          m_err;

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0000_0093;
            32'h4:   return 32'h0010_0113;
            default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
        endcase
    endfunction

    assign instruction = imem(PC_out);

    fetch_sequencer #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .PC_out(PC_out),
        .instruction(instruction), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .misalign_err(misalign_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc = RESET_PC; m_run = 0; m_trap = 0; m_err = 0;
    endtask

    task automatic model_check(input string where);
        chk({where, ".PC_out"}, PC_out, m_pc);
        chk({where, ".out_valid"}, {31'h0, out_valid}, {31'h0, mq.size() > 0});
        chk({where, ".out_pc"}, out_pc, (mq.size() > 0) ? mq[0][63:32] : 32'h0);
        chk({where, ".out_instr"}, out_instr, (mq.size() > 0) ? mq[0][31:0] : 32'h0);
        chk({where, ".misalign_err"}, {31'h0, misalign_err}, {31'h0, m_err});
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_update();
        bit pop, push;
        pop = (mq.size() > 0) && out_ready;
        if (redirect_valid) begin
            mq.delete();
`ifdef FETCH_ALIGN_CHECK_EN
            m_pc = redirect_pc;
            if (redirect_pc[1:0] != 2'b00) begin
                m_trap = 1; m_err = 1;
            end else if (m_trap) begin
                m_trap = 0; m_err = 0; m_run = fetch_en;
            end
`else
            m_pc = {redirect_pc[31:2], 2'b00};
`endif
        end else if (!m_trap) begin
            push = m_run && fetch_en && (mq.size() < DEPTH || pop);
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back({m_pc, imem(m_pc)});
                m_pc = m_pc + 32'd4;
            end
            m_run = fetch_en;
        end
    endtask

    task automatic step(input string where);
        @(negedge clk);
        model_check(where);
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic redir(input logic [31:0] pc);
        redirect_valid = 1'b1; redirect_pc = pc;
        step("redir");
        redirect_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        #12;
        chk("reset.PC_out", PC_out, RESET_PC);
        chk("reset.out_valid", {31'h0, out_valid}, 32'h0);
        chk("reset.out_pc", out_pc, 32'h0);
        chk("reset.out_instr", out_instr, 32'h0);
        chk("reset.misalign_err", {31'h0, misalign_err}, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Basic fetch: first entry visible two edges after fetch_en
        fetch_en = 1'b1; out_ready = 1'b1;
        step("t1a");
        chk("t1.valid_early", {31'h0, out_valid}, 32'h0);
        step("t1b");
        chk("t1.pc0", out_pc, 32'h0);
        chk("t1.instr0", out_instr, 32'h0000_0093);
        step("t1c");
        chk("t1.pc1", out_pc, 32'h4);
        chk("t1.instr1", out_instr, 32'h0010_0113);

        // Backpressure: queue saturates, PC stalls at 8
        out_ready = 1'b0;
        redir(32'h0);
        repeat (5) step("t2stall");
        chk("t2.pc_stall", PC_out, 32'h8);
        chk("t2.head_hold", out_pc, 32'h0);
        out_ready = 1'b1;
        step("t2r0");
        chk("t2.drain1", out_pc, 32'h4);
        step("t2r1");
        chk("t2.drain2", out_pc, 32'h8);

        // Redirect while full
        out_ready = 1'b0;
        redir(32'h0);
        repeat (2) step("t3fill");
        chk("t3.full_head", out_pc, 32'h0);
        out_ready = 1'b1;
        redir(32'h40);
        chk("t3.flushed", {31'h0, out_valid}, 32'h0);
        chk("t3.newpc", PC_out, 32'h40);
        step("t3b");
        chk("t3.first", out_pc, 32'h40);

        // PC wrap
        redir(32'hFFFF_FFFC);
        step("t4a"); chk("t4.pc_fffc", out_pc, 32'hFFFF_FFFC);
        step("t4b"); chk("t4.pc_0", out_pc, 32'h0);
        step("t4c"); chk("t4.pc_4", out_pc, 32'h4);

        // Stop fetch with two queued entries
        out_ready = 1'b0;
        redir(32'h0);
        repeat (2) step("t5fill");
        fetch_en = 1'b0; out_ready = 1'b1;
        repeat (2) step("t5drain");
        chk("t5.empty", {31'h0, out_valid}, 32'h0);
        chk("t5.pc_hold", PC_out, 32'h8);
        step("t5idle");
        chk("t5.pc_hold2", PC_out, 32'h8);
        fetch_en = 1'b1;
        repeat (3) step("t5run");
        #2 rst_n = 1'b0;
        #1;
        chk("t5.async_pc", PC_out, RESET_PC);
        chk("t5.async_valid", {31'h0, out_valid}, 32'h0);
        model_reset();
        @(posedge clk); #1 rst_n = 1'b1;

        // Misaligned redirect
        redir(32'h42);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("t6.err", {31'h0, misalign_err}, 32'h1);
        chk("t6.pc", PC_out, 32'h42);
        repeat (4) begin
            step("t6trap");
            chk("t6.trap_valid", {31'h0, out_valid}, 32'h0);
        end
`else
        chk("t6.err", {31'h0, misalign_err}, 32'h0);
        chk("t6.pc", PC_out, 32'h40);
        repeat (4) step("t6run");
`endif
        redir(32'h80);
        chk("t6.err_clear", {31'h0, misalign_err}, 32'h0);
        step("t6b");
        chk("t6.pc80", out_pc, 32'h80);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            fetch_en       = ($urandom_range(0, 9) != 0);
            out_ready      = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 3))
                0:       redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
                1:       redirect_pc = $urandom;
                default: redirect_pc = $urandom & ~32'h3;
            endcase
            step("rand");
        end
        redirect_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Drives the PC into the combinational instruction_memory (PC_out -> instruction) and sequences instruction fetch.
- Buffers fetched {pc, instruction} pairs in a small FIFO and presents them to decode over a valid/ready handshake.
- Handles stall (backpressure), branch/jump redirect with flush, and start/stop of fetch. Sits between instruction_memory and the decode stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC_out value after reset.
- DEPTH, 2, fetch queue entries. Must be a power of 2 and >= 2.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- fetch_en  in  1  1 = fetch permitted; 0 = stop issuing fetches
- PC_out  out  32  address to instruction_memory
- instruction  in  32  instruction_memory read data for the current PC_out, same cycle
- redirect_valid  in  1  branch/jump taken this cycle
- redirect_pc  in  32  redirect target
- out_valid  out  1  queue head valid
- out_ready  in  1  decode accepts head
- out_instr  out  32  head instruction
- out_pc  out  32  head PC
- misalign_err  out  1  misaligned redirect trap flag (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0):
  - PC_out=RESET_PC; queue empty (count=0).
  - out_valid=0, out_instr=0, out_pc=0, misalign_err=0.
  - state=IDLE.
- Release of reset is synchronous to clk. The first active edge is the first edge with rst_n=1.
- FSM states and transitions:
  - IDLE: no fetch. Goes to RUN on an edge where fetch_en=1.
  - RUN: fetches. Goes to IDLE on an edge where fetch_en=0.
  - TRAP: exists only with the feature.
- push (RUN only) occurs when fetch_en=1, redirect_valid=0, and (count<DEPTH or pop this cycle).
  - On push: enqueue {PC_out, instruction}; PC_out <= PC_out+4.
- pop = out_valid & out_ready; dequeues the head at the edge.
- Full queue with pop in the same cycle: push is allowed and count is unchanged.
- Full queue without pop: no push; PC_out holds (stall).
- Empty queue: out_valid=0, out_instr=0, out_pc=0. Otherwise out_* reflect the head combinationally from registers.
- Redirect (redirect_valid=1) has the highest priority, in any state:
  - Queue flushed to count=0.
  - PC_out <= redirect_pc.
  - No push that cycle; a pop in the same cycle is discarded.
  - State unchanged (except with the feature).
- Latency:
  - fetch_en rises at edge N: RUN at N, first push at N+1, out_valid=1 after N+1.
  - Redirect at edge M: first post-redirect instruction is visible after edge M+1.
- Throughput: 1 instruction/cycle while out_ready=1.
- Arithmetic: PC increment is modulo 2^32; 32'hFFFF_FFFC+4 = 32'h0.
- fetch_en=0 mid-run: stops pushes after the edge. The queue still drains via pop. PC_out holds the next unfetched address.
- Async reset mid-operation: immediately returns all state and outputs to reset values, discarding queue contents.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - A redirect with redirect_pc[1:0]!=0 flushes the queue, loads PC_out=redirect_pc, enters TRAP and sets misalign_err=1.
  - TRAP: no pushes; misalign_err holds 1.
  - An aligned redirect leaves TRAP: misalign_err<=0, PC_out<=redirect_pc, next state RUN if fetch_en=1 else IDLE.
  - Reset clears TRAP.
- Not defined:
  - PC_out <= {redirect_pc[31:2],2'b00}.
  - TRAP does not exist; misalign_err is tied 0.

Test Plan:
1. Reset, memory word0=32'h0000_0093, word1=32'h0010_0113; fetch_en=1, out_ready=1 -> out_valid=1 two edges after fetch_en; out_pc/out_instr = 0/32'h0000_0093 then 4/32'h0010_0113, one per cycle.
2. out_ready=0 for 5 cycles while fetching from 0 with DEPTH=2 -> count saturates at 2, PC_out stalls at 8, out_pc holds 0. Release out_ready -> pcs 0,4,8 in order, no gaps or duplicates.
3. Redirect to 32'h40 while queue is full (pcs 0,4) -> next cycle out_valid=0, PC_out=32'h40; following cycle out_pc=32'h40.
4. Redirect to 32'hFFFF_FFFC, fetch continuously -> out_pc sequence FFFF_FFFC, 0000_0000, 0000_0004.
5. Drop fetch_en with 2 entries queued, out_ready=1 -> both entries drain, then out_valid=0, PC_out constant. Assert rst_n=0 mid-stream -> PC_out=RESET_PC and out_valid=0 immediately, before the next clk edge.
6. With FETCH_ALIGN_CHECK_EN: redirect to 32'h42 -> misalign_err=1, out_valid=0 for 4 cycles; redirect to 32'h80 -> misalign_err=0, out_pc=32'h80 two edges later. Without the macro, the same redirect to 32'h42 -> PC_out=32'h40, misalign_err=0.
